// File: rtl/tick_gen_multi.sv
// Multi-channel programmable time-base: per-channel tick pulse and 50% square wave,
// with glitch-free divisor updates staged in a shadow register and applied at period boundaries.
module tick_gen_multi #(
  parameter int CLK_HZ = 50000000,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 27,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              restart,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic              div_ack,
  output logic              div_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] pend
);

  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(CLK_HZ);
  localparam logic [CH_W:0]    NUM_CH_W = (CH_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic wr_ok;
  assign wr_ok = div_wr && ({1'b0, div_ch} < NUM_CH_W);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_ack <= 1'b0;
      div_err <= 1'b0;
    end else begin
      div_ack <= div_wr;
      div_err <= div_wr && !wr_ok;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, div_q, shadow_q;
    logic [CNT_W-1:0] d_eff, cnt_nxt;
    logic             wrap, wr_hit, apply;
    logic             tick_q, sq_q, pend_q;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
      d_eff   = (div_q < MIN_DIV) ? MIN_DIV : div_q;
      // >= rather than == keeps the counter bounded if a smaller divisor lands
      // while the channel is paused above it.
      wrap    = en[i] && (cnt_q >= d_eff - ONE);
      cnt_nxt = wrap ? '0 : cnt_q + ONE;
      wr_hit  = wr_ok && (div_ch == CH_W'(i));
      apply   = pend_q && (restart || !en[i] || wrap);
    end

    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        cnt_q    <= '0;
        div_q    <= RST_DIV;
        shadow_q <= RST_DIV;
        tick_q   <= 1'b0;
        sq_q     <= 1'b0;
        pend_q   <= 1'b0;
      end else begin
        if (restart) begin
          cnt_q  <= '0;
          tick_q <= 1'b0;
          sq_q   <= 1'b0;
        end else if (en[i]) begin
          cnt_q  <= cnt_nxt;
          tick_q <= wrap;
          sq_q   <= (cnt_nxt >= (d_eff >> 1));
        end else begin
          tick_q <= 1'b0;
        end

        // Apply takes the pre-edge shadow; a simultaneous write stays pending.
        if (apply) div_q <= shadow_q;
        if (wr_hit) begin
          shadow_q <= div_val;
          pend_q   <= 1'b1;
        end else if (apply) begin
          pend_q   <= 1'b0;
        end
      end
    end

    assign tick[i] = tick_q;
    assign sq[i]   = sq_q;
    assign pend[i] = pend_q;
  end

endmodule
